audio_in_recorder: RTL and testbench
====================================

# audio_in_recorder

Capture-side companion to the ROM playback path: drains the Audio_Controller input FIFO through its read handshake and keeps the newest microphone sample. It scales each sample to 16 bits and writes it into an external sample RAM at the same fixed tick rate the playback path uses to step its ROM address. The block sits between Audio_Controller's audio-in outputs and a single-port RAM write port, so recorded clips can later be played back unchanged through the existing `<< 14` output path.

## Interface
- TICK_DIV, 2272: write tick period is TICK_DIV+1 clocks (≈22 kHz at 50 MHz)
- DEPTH, 117532: number of RAM words; last address DEPTH-1
- ADDR_W, 23: address / count width
- SHIFT, 14: input sample bits [SHIFT+15:SHIFT] are stored
- USE_RIGHT, 0: 0 records the left channel, 1 records the right channel

- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level; begin recording from address 0
- stop  in  1  level; end recording early
- audio_in_available  in  1  Audio_Controller input FIFO non-empty
- left_channel_audio_in  in  32  head-of-FIFO left sample
- right_channel_audio_in  in  32  head-of-FIFO right sample
- read_audio_in  out  1  FIFO pop pulse
- mem_we  out  1  RAM write enable, one-cycle pulse
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  16  RAM write data
- busy  out  1  high in RECORD
- done  out  1  high in DONE
- sample_count  out  ADDR_W  words written in current/last take

## Operation
- States: IDLE, RECORD, DONE.
- Drain runs in every state, so the FIFO never overflows:
  - registered rule: read_audio_in <= audio_in_available & ~read_audio_in.
  - On the same edge that sets read_audio_in, sample_q <= selected channel [SHIFT+15:SHIFT].
- Arithmetic: truncation only; no rounding or saturation.
- IDLE/DONE + start: go to RECORD; addr, tick counter and sample_count cleared; done cleared. start wins over a simultaneous stop.
- RECORD:
  - tick counter counts 0..TICK_DIV, then wraps to 0.
  - At the cycle the counter equals TICK_DIV: mem_we=1, mem_addr=addr, mem_wdata=sample_q; addr and sample_count increment on the next edge.
- RECORD + stop: go to DONE on the next edge. A write scheduled in that same cycle still completes; stop wins over start.
- Write at addr DEPTH-1: go to DONE; sample_count=DEPTH; addr does not wrap.
- In DONE, start is level-sensitive: held high, it re-arms immediately.
- mem_addr holds its last value outside write cycles; mem_wdata follows sample_q.

## Timing
- Reset values: read_audio_in=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, sample_count=0, sample_q=0, state IDLE.
- Reset asserted mid-RECORD: next edge returns to reset values with no further write; RAM contents are left as-is.
- start is sampled at edge E, and busy=1 after E. The first mem_we is in cycle E+TICK_DIV+1, with mem_addr=0. Writes then follow every TICK_DIV+1 cycles.
- Read handshake:
  - read_audio_in is high for at most 1 of every 2 cycles.
  - Pop-to-sample_q latency is 0: both are updated at the same edge.
  - The value is visible in mem_wdata one cycle later.
- With audio_in_available held high continuously, read_audio_in toggles 1,0,1,0.

## Structure
- Shared package holds the state enum (IDLE/RECORD/DONE) and the shared tick/depth/shift constants. The playback side uses the same constants so record and play rates match.
- One natural sub-module, rate_tick_gen:
  - parameter TICK_DIV; inputs clk, sync clear, enable; output a one-cycle tick.
  - Reused by playback.
- The FSM, drain logic and address counter stay in the top module.

## Test plan
- TICK_DIV=3, DEPTH=8, available held 1, left_in=32'h0012_C000 (SHIFT=14):
  - start pulse → mem_we at cycles 4, 8, …, 32 after start.
  - mem_addr 0..7, mem_wdata=16'h004B.
  - done=1, sample_count=8, no 9th write.
- available toggled irregularly with an incrementing left_in:
  - read_audio_in never high two cycles in a row; no pops while available=0.
  - every written word equals the most recently popped sample.
- stop asserted two cycles after the 3rd write → exactly 3 writes, sample_count=3, done=1, busy=0.
- start and stop high together:
  - in IDLE → RECORD.
  - in RECORD → DONE.
- reset pulsed mid-RECORD after 5 writes → all outputs 0 next cycle, IDLE. A new start restarts at mem_addr=0.
- USE_RIGHT=1, left_in=0, right_in=32'hFFFF_C000 → mem_wdata=16'hFFFF.

Source files
------------

// File: rtl/audio_in_recorder_pkg.sv
// Shared constants, state encoding and sample scaling for the audio record/playback paths.
package audio_in_recorder_pkg;

  localparam int unsigned TICK_DIV_DEF = 2272;
  localparam int unsigned DEPTH_DEF    = 117532;
  localparam int unsigned ADDR_W_DEF   = 23;
  localparam int unsigned SHIFT_DEF    = 14;
  localparam int unsigned AUDIO_W      = 32;
  localparam int unsigned SAMPLE_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_DONE   = 2'd2
  } rec_state_e;

  // Keep bits [shift+15:shift] of a raw codec word; plain truncation.
  function automatic logic [SAMPLE_W-1:0] scale_sample(input logic [AUDIO_W-1:0] raw,
                                                       input int unsigned shift);
    return SAMPLE_W'(raw >> shift);
  endfunction

endpackage

// File: rtl/audio_in_recorder_if.sv
// Audio-in FIFO read side plus sample-RAM write port seen by the recorder.
interface audio_in_recorder_if #(
  parameter int unsigned ADDR_W = audio_in_recorder_pkg::ADDR_W_DEF
) ();
  import audio_in_recorder_pkg::*;

  logic                audio_in_available;
  logic [AUDIO_W-1:0]  left_channel_audio_in;
  logic [AUDIO_W-1:0]  right_channel_audio_in;
  logic                read_audio_in;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [SAMPLE_W-1:0] mem_wdata;

  modport master (
    input  audio_in_available, left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output audio_in_available, left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/audio_in_recorder_rate_tick_gen.sv
// Fixed-rate tick: one-cycle pulse every TICK_DIV+1 enabled clocks, shared with playback.
module rate_tick_gen #(
  parameter int unsigned TICK_DIV = 2272
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered one count early so it is high exactly while the count equals TICK_DIV.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d  = (cnt_q == CNT_W'(TICK_DIV)) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 1));
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    tick_q <= tick_d;
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/audio_in_recorder.sv
// Drains the codec input FIFO and writes the newest scaled sample to sample RAM at the playback tick rate.
module audio_in_recorder
  import audio_in_recorder_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned SHIFT     = SHIFT_DEF,
  parameter bit          USE_RIGHT = 1'b0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  audio_in_recorder_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  sample_count
);

  rec_state_e          state_q, state_d;
  logic                rd_q, rd_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [AUDIO_W-1:0]  chan_c;
  logic                arm_c, rec_c, tick_c;

  assign chan_c = USE_RIGHT ? bus.right_channel_audio_in : bus.left_channel_audio_in;
  assign rec_c  = (state_q == ST_RECORD);
  assign arm_c  = !rec_c && start;

  rate_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (CLOCK_50),
    .clr_i (reset | arm_c),
    .en_i  (rec_c),
    .tick_o(tick_c)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = bus.audio_in_available & ~rd_q;
    sample_d   = sample_q;
    wdata_d    = sample_q;
    we_d       = 1'b0;
    mem_addr_d = mem_addr_q;
    addr_d     = addr_q;
    count_d    = count_q;

    // FIFO is drained in every state so it cannot overflow while idle.
    if (rd_d) sample_d = scale_sample(chan_c, SHIFT);

    case (state_q)
      ST_RECORD: begin
        if (tick_c) begin
          we_d       = 1'b1;
          mem_addr_d = addr_q;
          count_d    = count_q + ADDR_W'(1);
          if (addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
          else                              addr_d  = addr_q + ADDR_W'(1);
        end
        if (stop) state_d = ST_DONE;
      end
      default: begin
        if (start) begin
          state_d = ST_RECORD;
          addr_d  = '0;
          count_d = '0;
        end
      end
    endcase

    busy_d = (state_d == ST_RECORD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sample_q   <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sample_q   <= sample_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
    end
  end

  assign bus.read_audio_in = rd_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign sample_count      = count_q;

endmodule

// File: tb/tb_audio_in_recorder.sv
// Self-checking bench for audio_in_recorder: start/stop table, full takes, random FIFO traffic, reset and right channel.
module tb_audio_in_recorder;
  import audio_in_recorder_pkg::*;

  localparam int unsigned TD     = 3;
  localparam int unsigned PERIOD = TD + 1;
  localparam int unsigned DEP    = 8;
  localparam int unsigned AW     = 23;
  localparam int unsigned SH     = 14;

  logic clk = 1'b0;
  logic reset, start, stop, start2, stop2;
  logic busy, done, busy2, done2;
  logic [AW-1:0] count, count2;

  audio_in_recorder_if #(.ADDR_W(AW)) bus  ();
  audio_in_recorder_if #(.ADDR_W(AW)) bus2 ();

  audio_in_recorder #(.TICK_DIV(TD), .DEPTH(DEP), .ADDR_W(AW), .SHIFT(SH), .USE_RIGHT(1'b0)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .bus(bus),
    .busy(busy), .done(done), .sample_count(count)
  );

  audio_in_recorder #(.TICK_DIV(TD), .DEPTH(DEP), .ADDR_W(AW), .SHIFT(SH), .USE_RIGHT(1'b1)) dut_r (
    .CLOCK_50(clk), .reset(reset), .start(start2), .stop(stop2), .bus(bus2),
    .busy(busy2), .done(done2), .sample_count(count2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cyc[$];
  int          wr_addr[$];
  logic [15:0] wr_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: pop whenever the FIFO had data and the last cycle was not a pop; RAM data is the
  // most recent popped sample as it stood one cycle earlier.
  bit          armed    = 1'b0;
  logic        prev_av  = 1'b0;
  logic        prev_rd  = 1'b0;
  logic        prev_rst = 1'b1;
  logic [15:0] pend     = 16'h0;
  logic [15:0] sq       = 16'h0;

  always @(negedge clk) begin : monitor
    logic        exp_rd_m;
    logic [15:0] exp_wd_m;
    exp_rd_m = prev_rst ? 1'b0 : (prev_av & ~prev_rd);
    exp_wd_m = prev_rst ? 16'h0 : sq;
    if (prev_rst)      sq = 16'h0;
    else if (exp_rd_m) sq = pend;
    if (armed) begin
      check("pop", 32'(bus.read_audio_in), 32'(exp_rd_m));
      if (bus.mem_we === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(bus.mem_addr));
        wr_data.push_back(bus.mem_wdata);
        check("wdata", 32'(bus.mem_wdata), 32'(exp_wd_m));
      end
    end
    pend     = 16'(bus.left_channel_audio_in >> SH);
    prev_av  = bus.audio_in_available;
    prev_rd  = exp_rd_m;
    prev_rst = reset;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_writes();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0    = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (wr_cyc.size() >= n) return;
      step();
    end
    check(name, 32'(wr_cyc.size()), 32'(n));
  endtask

  task automatic check_take(input int t0, input int n, input string name);
    check({name, "_nwr"}, 32'(wr_cyc.size()), 32'(n));
    for (int k = 0; k < wr_cyc.size() && k < n; k++) begin
      check({name, "_wcyc"}, 32'(wr_cyc[k]), 32'(t0 + int'(PERIOD) * (k + 1)));
      check({name, "_waddr"}, 32'(wr_addr[k]), 32'(k));
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_rd"},    32'(bus.read_audio_in), 32'h0);
    check({name, "_we"},    32'(bus.mem_we),        32'h0);
    check({name, "_addr"},  32'(bus.mem_addr),      32'h0);
    check({name, "_wdata"}, 32'(bus.mem_wdata),     32'h0);
    check({name, "_busy"},  32'(busy),              32'h0);
    check({name, "_done"},  32'(done),              32'h0);
    check({name, "_count"}, 32'(count),             32'h0);
  endtask

  typedef struct {
    logic start;
    logic stop;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    watchdog_block: begin
      fork
        begin
          #100000;
          $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
          $fatal(1, "watchdog");
        end
      join_none
    end
  end

  initial begin
    int t0;
    logic [31:0] lval;

    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // IDLE: start beats stop
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};  // RECORD: stop beats start
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};  // DONE re-arms
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // DONE: start beats stop
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    bus.audio_in_available     = 1'b0;
    bus.left_channel_audio_in  = 32'h0;
    bus.right_channel_audio_in = 32'h0;
    bus2.audio_in_available     = 1'b1;
    bus2.left_channel_audio_in  = 32'h0;
    bus2.right_channel_audio_in = 32'hFFFF_C000;
    step();
    armed = 1'b1;
    step();
    check_zero("reset");
    reset = 1'b0;
    step();

    // start/stop priority table, one edge per row
    foreach (tbl[i]) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_count", i), 32'(count), 32'h0);
      #1;
    end
    start = 1'b0; stop = 1'b0;
    step();

    // full take with a constant sample
    bus.audio_in_available    = 1'b1;
    bus.left_channel_audio_in = 32'h0012_C000;
    clear_writes();
    pulse_start(t0);
    check("take_busy", 32'(busy), 32'h1);
    wait_writes(int'(DEP), 60, "take_timeout");
    repeat (12) step();
    check_take(t0, int'(DEP), "take");
    foreach (wr_data[k]) check("take_data", 32'(wr_data[k]), 32'h0000_004B);
    check("take_done", 32'(done), 32'h1);
    check("take_busy_end", 32'(busy), 32'h0);
    check("take_count", 32'(count), 32'(DEP));
    check("take_addr_hold", 32'(bus.mem_addr), 32'(DEP - 1));

    // random FIFO availability with an incrementing sample stream
    clear_writes();
    lval  = 32'h0001_0000;
    start = 1'b1;
    t0    = cyc + 1;
    for (int i = 0; i < 50; i++) begin
      bus.audio_in_available    = (i % 16 < 8) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
      lval                      = lval + 32'h0000_4A5B;
      bus.left_channel_audio_in = lval;
      step();
      start = 1'b0;
    end
    check_take(t0, int'(DEP), "rand");
    check("rand_count", 32'(count), 32'(DEP));

    // stop two cycles after the third write
    bus.audio_in_available = 1'b1;
    clear_writes();
    pulse_start(t0);
    wait_writes(3, 40, "stop_timeout");
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (14) step();
    check_take(t0, 3, "stop");
    check("stop_count", 32'(count), 32'h3);
    check("stop_done", 32'(done), 32'h1);
    check("stop_busy", 32'(busy), 32'h0);

    // reset in the middle of a take
    clear_writes();
    pulse_start(t0);
    wait_writes(5, 60, "rst_timeout");
    reset = 1'b1;
    step();
    check_zero("midrst");
    reset = 1'b0;
    repeat (8) step();
    check("midrst_nwr", 32'(wr_cyc.size()), 32'h5);
    check("midrst_idle_busy", 32'(busy), 32'h0);
    check("midrst_idle_done", 32'(done), 32'h0);
    clear_writes();
    pulse_start(t0);
    wait_writes(1, 20, "restart_timeout");
    check_take(t0, 1, "restart");

    // right-channel instance
    pulse_start_r: begin
      int t2;
      int seen;
      start2 = 1'b1;
      t2     = cyc + 1;
      step();
      start2 = 1'b0;
      seen   = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
        if (bus2.mem_we === 1'b1) begin
          seen = 1;
          check("right_wcyc", 32'(cyc), 32'(t2 + int'(PERIOD)));
          check("right_addr", 32'(bus2.mem_addr), 32'h0);
          check("right_data", 32'(bus2.mem_wdata), 32'h0000_FFFF);
        end else begin
          step();
        end
      end
      check("right_seen", 32'(seen), 32'h1);
      check("right_busy", 32'(busy2), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
